fan_cmd_scheduler: RTL and testbench

- Sequences the RF packet generator: accepts fan commands from NUM_REQ requesters, arbitrates round-robin, and drives the generator's start/cmd inputs.
- Each accepted command is transmitted REPEATS times, with a fixed inter-packet gap between transmissions.
- The generator has no busy/done output, so this block times each packet itself and holds cmd stable for the whole transmission.

---
 rtl/fan_pkg.sv | 22 ++
 rtl/fan_rr_arbiter.sv | 37 +++
 rtl/fan_cmd_scheduler.sv | 153 +++++++++++++++
 tb/tb_fan_cmd_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared definitions for the fan command scheduler: command limits, packet timing
// constants and the sequencer state encoding.
package fan_pkg;

   localparam int FAN_CMD_W          = 3;
   localparam logic [2:0] FAN_CMD_MAX = 3'd4;
   localparam int FAN_PHASE_CYCLES   = 1836;
   localparam int FAN_PHASES_PER_PKT = 39;
   localparam int FAN_GAP_PHASES     = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SEND  = 2'd2,
      GAP   = 2'd3
   } fan_state_e;

   function automatic logic fan_cmd_ok(input logic [FAN_CMD_W-1:0] cmd);
      return (cmd <= FAN_CMD_MAX);
   endfunction

endpackage

// File: rtl/fan_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above ptr (with wrap), one-hot plus
// encoded index. Purely combinational so the grant can be used as a same-cycle ready.
module fan_rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [2:0]         grant_idx
);

   logic [2:0] cand_s;
   logic       found_s;

   // search from ptr+1 upward, first hit wins
   always_comb begin
      grant_idx = 3'd0;
      found_s   = 1'b0;
      cand_s    = 3'd0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s = 3'((int'(ptr) + k) % NUM_REQ);
         if (enable && !found_s && (|(req & (NUM_REQ'(1) << cand_s)))) begin
            grant_idx = cand_s;
            found_s   = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      if (found_s) begin
         grant = NUM_REQ'(1) << grant_idx;
      end else begin
         grant = {NUM_REQ{1'b0}};
      end
   end

endmodule

// File: rtl/fan_cmd_scheduler.sv
// Accepts fan commands from several requesters and replays each accepted command
// REPEATS times into the packet generator, timing packets and gaps itself.
module fan_cmd_scheduler
   import fan_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int PACKET_CYCLES = FAN_PHASE_CYCLES * FAN_PHASES_PER_PKT,
   parameter int GAP_CYCLES    = FAN_PHASE_CYCLES * FAN_GAP_PHASES,
   parameter int REPEATS       = 4,
   parameter int TIMER_WIDTH   = 20,
   parameter int RPT_WIDTH     = 3
) (
   input  logic                   ref_clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [3*NUM_REQ-1:0]   req_cmd,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   gen_start,
   output logic [FAN_CMD_W-1:0]   gen_cmd,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [2:0]             active_id
);

   fan_state_e                 state_r, next_state_s;
   logic [TIMER_WIDTH-1:0]     timer_r, next_timer_s;
   logic [RPT_WIDTH-1:0]       rpt_r, next_rpt_s;
   logic [2:0]                 ptr_r, next_ptr_s;
   logic [2:0]                 active_id_r, next_id_s;
   logic [2:0]                 grant_idx_s;
   logic [FAN_CMD_W-1:0]       gen_cmd_r, next_cmd_s, sel_cmd_s;
   logic [NUM_REQ-1:0]         grant_s;
   logic                       arb_en_s, accept_s, err_s, done_s;
   logic                       gen_start_r, done_r, err_r;

   // no grants while reset is asserted, so nothing is accepted in a reset cycle
   assign arb_en_s = (state_r == IDLE) && reset_n;
   assign accept_s = |grant_s;

   fan_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_r),
      .enable    (arb_en_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   // command of the granted requester
   always_comb begin
      sel_cmd_s = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s[i]) begin
            sel_cmd_s = req_cmd[3*i +: 3];
         end else begin
            sel_cmd_s = sel_cmd_s;
         end
      end
   end

   // next-state and next-value logic for the sequencer
   always_comb begin
      next_state_s = state_r;
      next_timer_s = timer_r;
      next_rpt_s   = rpt_r;
      next_ptr_s   = ptr_r;
      next_cmd_s   = gen_cmd_r;
      next_id_s    = active_id_r;
      err_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               next_ptr_s = grant_idx_s;
               if (fan_cmd_ok(sel_cmd_s)) begin
                  next_cmd_s   = sel_cmd_s;
                  next_id_s    = grant_idx_s;
                  next_rpt_s   = RPT_WIDTH'(REPEATS - 1);
                  next_state_s = START;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         START: begin
            next_timer_s = TIMER_WIDTH'(PACKET_CYCLES - 1);
            next_state_s = SEND;
         end
         SEND: begin
            if (timer_r == {TIMER_WIDTH{1'b0}}) begin
               next_timer_s = TIMER_WIDTH'(GAP_CYCLES - 1);
               next_state_s = GAP;
            end else begin
               next_timer_s = timer_r - TIMER_WIDTH'(1);
            end
         end
         GAP: begin
            if (timer_r == {TIMER_WIDTH{1'b0}}) begin
               if (rpt_r != {RPT_WIDTH{1'b0}}) begin
                  next_rpt_s   = rpt_r - RPT_WIDTH'(1);
                  next_state_s = START;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_timer_s = timer_r - TIMER_WIDTH'(1);
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // done is registered one cycle early so it coincides with the final gap cycle
   assign done_s = (next_state_s == GAP) && (next_timer_s == {TIMER_WIDTH{1'b0}}) &&
                   (next_rpt_s == {RPT_WIDTH{1'b0}});

   // sequencer state and registered outputs
   always_ff @(posedge ref_clk) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         timer_r     <= {TIMER_WIDTH{1'b0}};
         rpt_r       <= {RPT_WIDTH{1'b0}};
         ptr_r       <= 3'(NUM_REQ - 1);
         gen_cmd_r   <= 3'd0;
         active_id_r <= 3'd0;
         gen_start_r <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         timer_r     <= next_timer_s;
         rpt_r       <= next_rpt_s;
         ptr_r       <= next_ptr_s;
         gen_cmd_r   <= next_cmd_s;
         active_id_r <= next_id_s;
         gen_start_r <= (next_state_s == START);
         done_r      <= done_s;
         err_r       <= err_s;
      end
   end

   assign req_ready = grant_s;
   assign gen_start = gen_start_r;
   assign gen_cmd   = gen_cmd_r;
   assign busy      = (state_r != IDLE);
   assign done      = done_r;
   assign err       = err_r;
   assign active_id = active_id_r;

endmodule

// File: tb/tb_fan_cmd_scheduler.sv
// Self-checking bench for fan_cmd_scheduler: directed scenarios plus random traffic,
// all checked against a job-elapsed-time reference model.
module tb_fan_cmd_scheduler;

   localparam int N   = 2;
   localparam int P   = 10;
   localparam int G   = 4;
   localparam int R   = 2;
   localparam int JOB = R * (P + G + 1);
   localparam int VW  = N + 10;

   logic           ref_clk   = 1'b0;
   logic           reset_n   = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [3*N-1:0] req_cmd   = '0;
   logic [N-1:0]   req_ready;
   logic           gen_start;
   logic [2:0]     gen_cmd;
   logic           busy, done, err;
   logic [2:0]     active_id;
   logic [VW-1:0]  obs;

   int checks   = 0;
   int failures = 0;

   // reference model: a job is just "cycles elapsed since accept"
   bit m_busy = 1'b0;
   int m_k    = 0;
   int m_ptr  = N - 1;
   int m_cmd  = 0;
   int m_id   = 0;
   bit m_err  = 1'b0;
   int m_grant = -1;

   fan_cmd_scheduler #(
      .NUM_REQ(N), .PACKET_CYCLES(P), .GAP_CYCLES(G), .REPEATS(R),
      .TIMER_WIDTH(20), .RPT_WIDTH(3)
   ) dut (
      .ref_clk(ref_clk), .reset_n(reset_n), .req_valid(req_valid), .req_cmd(req_cmd),
      .req_ready(req_ready), .gen_start(gen_start), .gen_cmd(gen_cmd), .busy(busy),
      .done(done), .err(err), .active_id(active_id)
   );

   assign obs = {req_ready, gen_start, gen_cmd, busy, done, err, active_id};

   always #5 ref_clk = ~ref_clk;

   function automatic int rr_pick();
      logic [N-1:0] tv;
      if (m_busy || !reset_n) return -1;
      for (int k = 1; k <= N; k++) begin
         int c;
         c  = (m_ptr + k) % N;
         tv = req_valid >> c;
         if (tv[0]) return c;
      end
      return -1;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      int g;
      logic [N-1:0] r;
      logic s, d;
      g = rr_pick();
      r = (g >= 0) ? (N'(1) << g) : '0;
      s = m_busy && (((m_k - 1) % (P + G + 1)) == 0);
      d = m_busy && (m_k == JOB);
      return {r, s, 3'(m_cmd), m_busy, d, m_err, 3'(m_id)};
   endfunction

   task automatic model_edge();
      int g;
      logic [3*N-1:0] tc;
      int c;
      g = rr_pick();
      m_grant = -1;
      if (!reset_n) begin
         m_busy = 1'b0; m_k = 0; m_ptr = N - 1; m_cmd = 0; m_id = 0; m_err = 1'b0;
      end else begin
         m_err = 1'b0;
         if (m_busy) begin
            if (m_k == JOB) m_busy = 1'b0;
            else m_k++;
         end else if (g >= 0) begin
            m_grant = g;
            m_ptr   = g;
            tc      = req_cmd >> (3 * g);
            c       = int'(tc[2:0]);
            if (c <= 4) begin
               m_busy = 1'b1; m_k = 1; m_cmd = c; m_id = g;
            end else begin
               m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge ref_clk);
      model_edge();
      #1;
   endtask

   task automatic drop_granted();
      if (m_grant >= 0) req_valid = req_valid & ~(N'(1) << m_grant);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = 2'b11;
      req_cmd   = {3'd2, 3'd1};
      tick();
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model c=%0d got=%h exp=%h", c, obs, exp_vec());
         end
         checks++;
         if (req_ready !== 2'b00 || busy !== 1'b0 || gen_start !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle c=%0d ready=%b busy=%b start=%b done=%b", c, req_ready, busy, gen_start, done);
         end
         tick();
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL reset_first_grant got=%b exp=01", req_ready);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_single();
      int st[$];
      int done_at = -1;
      logic busy31 = 1'bx;
      req_cmd   = {3'd0, 3'd3};
      req_valid = 2'b01;
      for (int c = 0; c <= 32; c++) begin
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL single c=%0d got=%h exp=%h", c, obs, exp_vec());
         end
         if (gen_start === 1'b1) st.push_back(c);
         if (done === 1'b1) done_at = c;
         if (c == 31) busy31 = busy;
         tick();
         drop_granted();
      end
      checks++;
      if (st.size() != 2 || st[0] != 1 || st[1] != 16) begin
         failures++;
         $display("FAIL single_starts count=%0d first=%0d exp 2 starts at 1,16", st.size(), (st.size() > 0) ? st[0] : -1);
      end
      checks++;
      if (done_at != 30 || busy31 !== 1'b0) begin
         failures++;
         $display("FAIL single_done done_at=%0d busy31=%b exp 30/0", done_at, busy31);
      end
   endtask

   task automatic test_contention();
      int order[$];
      logic [2:0] cmd40 = 3'bx;
      do_reset();
      req_cmd   = {3'd2, 3'd1};
      req_valid = 2'b11;
      for (int c = 0; c < 64; c++) begin
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL contention c=%0d got=%h exp=%h", c, obs, exp_vec());
         end
         if (req_ready !== 2'b00) order.push_back((req_ready === 2'b10) ? 1 : 0);
         if (c == 40) cmd40 = gen_cmd;
         tick();
      end
      checks++;
      if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
         failures++;
         $display("FAIL contention_order grants=%0d first=%0d exp order 0,1,0", order.size(), (order.size() > 0) ? order[0] : -1);
      end
      checks++;
      if (cmd40 !== 3'd2) begin
         failures++;
         $display("FAIL contention_cmd got=%0d exp=2", cmd40);
      end
   endtask

   task automatic test_invalid();
      int nerr = 0;
      do_reset();
      req_cmd   = {3'd0, 3'd0};
      req_valid = 2'b01;
      for (int c = 0; c <= JOB; c++) begin
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL invalid_pre c=%0d got=%h exp=%h", c, obs, exp_vec());
         end
         tick();
         drop_granted();
      end
      req_cmd   = {3'd6, 3'd2};
      req_valid = 2'b11;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL invalid c=%0d got=%h exp=%h", c, obs, exp_vec());
         end
         if (err === 1'b1) nerr++;
         if (c == 0) begin
            checks++;
            if (req_ready !== 2'b10) begin
               failures++;
               $display("FAIL invalid_grant got=%b exp=10", req_ready);
            end
         end
         if (c == 1) begin
            checks++;
            if (err !== 1'b1 || req_ready !== 2'b01 || busy !== 1'b0 || gen_start !== 1'b0) begin
               failures++;
               $display("FAIL invalid_err err=%b ready=%b busy=%b start=%b exp 1/01/0/0", err, req_ready, busy, gen_start);
            end
         end
         tick();
         drop_granted();
      end
      checks++;
      if (nerr != 1) begin
         failures++;
         $display("FAIL invalid_err_count got=%0d exp=1", nerr);
      end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      do_reset();
      req_cmd   = {3'd0, 3'd4};
      req_valid = 2'b01;
      for (int c = 0; c <= 6 + JOB + 2; c++) begin
         reset_n = (c == 5) ? 1'b0 : 1'b1;
         if (c == 6) begin
            req_cmd   = {3'd2, 3'd0};
            req_valid = 2'b10;
         end
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs, exp_vec());
         end
         if (c == 6) begin
            checks++;
            if (gen_cmd !== 3'd0 || busy !== 1'b0 || gen_start !== 1'b0 || done !== 1'b0) begin
               failures++;
               $display("FAIL reset_mid_idle cmd=%0d busy=%b start=%b done=%b exp 0/0/0/0", gen_cmd, busy, gen_start, done);
            end
         end
         if (done === 1'b1) ndone++;
         tick();
         drop_granted();
      end
      checks++;
      if (ndone != 1) begin
         failures++;
         $display("FAIL reset_mid_done_count got=%0d exp=1", ndone);
      end
   endtask

   task automatic test_late();
      int first1 = -1;
      do_reset();
      req_cmd   = {3'd3, 3'd1};
      req_valid = 2'b01;
      for (int c = 0; c <= 34; c++) begin
         if (c == 8) req_valid = req_valid | 2'b10;
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL late c=%0d got=%h exp=%h", c, obs, exp_vec());
         end
         if (req_ready[1] === 1'b1 && first1 < 0) first1 = c;
         tick();
         drop_granted();
      end
      checks++;
      if (first1 != 31) begin
         failures++;
         $display("FAIL late_grant got=%0d exp=31", first1);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] tv;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         for (int i = 0; i < N; i++) begin
            tv = req_valid >> i;
            if (!tv[0] && $urandom_range(0, 5) == 0) begin
               req_cmd[3*i +: 3] = 3'($urandom_range(0, 7));
               req_valid = req_valid | (N'(1) << i);
            end
         end
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_vec());
         end
         tick();
         drop_granted();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_invalid();
      test_reset_mid();
      test_late();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
